// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at issue, held in a pending register, and committed after a fixed busy count.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,  OP_MSUB  = 4'd9, OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic               commit_q, commit_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, div_b, quo, rem, q_res, r_res;

  always_comb begin
    is_signed = 1'b0;
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed = 1'b1;
      default:                           is_signed = 1'b0;
    endcase
  end

  always_comb begin
    ext_a = is_signed ? {{WIDTH{opA[WIDTH-1]}}, opA} : {{WIDTH{1'b0}}, opA};
    ext_b = is_signed ? {{WIDTH{opB[WIDTH-1]}}, opB} : {{WIDTH{1'b0}}, opB};
    prod  = ext_a * ext_b;
    acc   = {hi_q, lo_q};
    // Sign-magnitude divide: MIN / -1 naturally yields lo=MIN, hi=0 since |MIN| wraps to MIN.
    a_neg = is_signed & opA[WIDTH-1];
    b_neg = is_signed & opB[WIDTH-1];
    mag_a = a_neg ? -opA : opA;
    mag_b = b_neg ? -opB : opB;
    div_b = (opB == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    quo   = mag_a / div_b;
    rem   = mag_a % div_b;
    q_res = (a_neg ^ b_neg) ? -quo : quo;
    r_res = a_neg ? -rem : rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              if (op == OP_MADD || op == OP_MADDU)      pend_d = acc + prod;
              else if (op == OP_MSUB || op == OP_MSUBU) pend_d = acc - prod;
              else                                      pend_d = prod;
              commit_d = 1'b1;
              cnt_d    = CW'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_d   = {r_res, q_res};
              commit_d = (opB != '0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_MTHI: hi_d = opA;
            OP_MTLO: lo_d = opA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (commit_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default parameters.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;
  int          n;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    issue(4'd1, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    issue(4'd2, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(4'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(4'd3, 32'h00000007, 32'hFFFFFFFE);
    wait_idle(n);
    check("div_negb_lo", lo, 32'hFFFFFFFD);
    check("div_negb_hi", hi, 32'h00000001);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);

    issue(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(4'd5, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(4'd6, 32'h9ABCDEF0, 32'h0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(4'd4, 32'd5, 32'd0);
    check("divz_hold_hi", hi, 32'h12345678);
    wait_idle(n);
    check("divz_cycles", n, 32'd10);
    check("divz_hi", hi, 32'h12345678);
    check("divz_lo", lo, 32'h9ABCDEF0);

    issue(4'd8, 32'h00010000, 32'h00010000);
    wait_idle(n);
    check("maddu_hi", hi, 32'h12345679);
    check("maddu_lo", lo, 32'h9ABCDEF0);

    issue(4'd9, 32'h00000001, 32'h00000001);
    wait_idle(n);
    check("msub_hi", hi, 32'h12345679);
    check("msub_lo", lo, 32'h9ABCDEEF);

    issue(4'd7, 32'hFFFFFFFF, 32'h00000001);
    wait_idle(n);
    check("madd_hi", hi, 32'h12345679);
    check("madd_lo", lo, 32'h9ABCDEEE);

    // mtlo presented during the first busy cycle of a mult must be ignored
    issue(4'd1, 32'd3, 32'd3);
    start = 1'b1; op = 4'd6; opA = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("busy_mtlo_lo", lo, 32'h9ABCDEEE);
    check("busy_mtlo_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("busy_mtlo_cycles", n, 32'd4);
    check("busy_mult_hi", hi, 32'h0);
    check("busy_mult_lo", lo, 32'd9);

    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_hi", hi, 32'h0);
    check("areset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    check("areset_hold_lo", lo, 32'h0);

    issue(4'd1, 32'd7, 32'hFFFFFFFD);
    wait_idle(n);
    check("post_reset_cycles", n, 32'd5);
    check("post_reset_hi", hi, 32'hFFFFFFFF);
    check("post_reset_lo", lo, 32'hFFFFFFEB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
